// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (receiver state encoding, defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_DEFAULT_DATA_BITS  = 8;
    localparam int c_DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : bit_synchronizer
// Description : Two-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver, 1 start / DATA_BITS LSB-first / 1 stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = c_DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = c_DEFAULT_OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // The edge tick is tick #1 and clears the counter, so the start bit is
    // sampled when the counter is about to reach OVERSAMPLE/2-1.
    localparam logic [TICK_W-1:0] c_HALF_SAMPLE = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [TICK_W-1:0] c_FULL_SAMPLE = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  c_LAST_BIT    = BIT_W'(DATA_BITS - 1);

    generate
        if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
            $error("uart_rx: OVERSAMPLE must be even and >= 4");
        end
    endgenerate

    rx_state_t            r_state, w_state_next;
    logic [TICK_W-1:0]    r_tick_cnt, w_tick_cnt_next;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS:0]   w_shift_wide;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_frame_error;
    logic                 w_load, w_ferr;
    logic                 w_rx_s;
    logic                 r_rx_d;

    bit_synchronizer #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

    assign w_shift_wide = {w_rx_s, r_shift};

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_load          = 1'b0;
        w_ferr          = 1'b0;
        if (tick) begin
            case (r_state)
                RX_IDLE: begin
                    if (r_rx_d && !w_rx_s) begin
                        w_tick_cnt_next = '0;
                        w_bit_cnt_next  = '0;
                        w_state_next    = RX_START;
                    end
                end
                RX_START: begin
                    if (r_tick_cnt == c_HALF_SAMPLE) begin
                        w_tick_cnt_next = '0;
                        w_state_next    = w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_tick_cnt == c_FULL_SAMPLE) begin
                        w_shift_next    = w_shift_wide[DATA_BITS:1];
                        w_tick_cnt_next = '0;
                        w_bit_cnt_next  = r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_state_next = RX_STOP;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_tick_cnt == c_FULL_SAMPLE) begin
                        w_load          = w_rx_s;
                        w_ferr          = !w_rx_s;
                        w_tick_cnt_next = '0;
                        w_state_next    = RX_IDLE;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    w_state_next = RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= RX_IDLE;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_rx_d        <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_tick_cnt    <= w_tick_cnt_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_shift       <= w_shift_next;
            r_valid       <= w_load;
            r_frame_error <= w_ferr;
            r_rx_d        <= w_rx_s;
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (DATA_BITS=8, OVERSAMPLE=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int NB  = 8;
    localparam int OVS = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          tick;
    logic          rx;
    logic [NB-1:0] data;
    logic          valid;
    logic          frame_error;
    logic          busy;

    uart_rx #(
        .DATA_BITS  (NB),
        .OVERSAMPLE (OVS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_valid, n_ferr, n_both, first_valid;
    logic saw_busy;

    typedef struct {
        string        name;
        logic [NB-1:0] word;
        logic         stop_bit;
        logic         tail;
        int           div;
        int           exp_valid;
        int           exp_ferr;
        logic [NB-1:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        n_valid     = 0;
        n_ferr      = 0;
        n_both      = 0;
        first_valid = -1;
        saw_busy    = 1'b0;
    endtask

    task automatic observe(input int j);
        if (valid === 1'b1) begin
            if (first_valid < 0) first_valid = j;
            n_valid++;
        end
        if (frame_error === 1'b1) n_ferr++;
        if (valid === 1'b1 && frame_error === 1'b1) n_both++;
        if (busy === 1'b1) saw_busy = 1'b1;
    endtask

    task automatic idle_line(input int n, input logic level);
        for (int j = 0; j < n; j++) begin
            @(posedge clock); #1;
            observe(j);
            rx    = level;
            tick  = 1'b1;
            reset = 1'b0;
        end
    endtask

    // Drives one frame clock by clock. Iteration j's observation reflects
    // the inputs driven in iteration j-1; ticks land on j%div == 2 so the
    // first tick coincides with the synchronized falling edge.
    task automatic run_frame(input logic [NB-1:0] word, input logic stop_bit,
                             input logic tail, input int div, input int extra,
                             input int rst_at);
        int total;
        int idx;
        total = (NB + 2) * OVS * div + extra;
        for (int j = 0; j < total; j++) begin
            @(posedge clock); #1;
            observe(j);
            idx = j / (OVS * div);
            if (rst_at >= 0 && j >= rst_at) rx = 1'b1;
            else if (idx == 0)              rx = 1'b0;
            else if (idx <= NB)             rx = word[idx-1];
            else if (idx == NB + 1)         rx = stop_bit;
            else                            rx = tail;
            tick  = ((j % div) == (2 % div));
            reset = (rst_at >= 0 && j >= rst_at && j < rst_at + 2);
        end
    endtask

    initial begin
        vecs[0] = '{"a5_good",   8'hA5, 1'b1, 1'b1, 1, 1, 0, 8'hA5};
        vecs[1] = '{"3c_badstop",8'h3C, 1'b0, 1'b0, 1, 0, 1, 8'hA5};
        vecs[2] = '{"5b_recover",8'h5B, 1'b1, 1'b1, 1, 1, 0, 8'h5B};
        vecs[3] = '{"c3_div5",   8'hC3, 1'b1, 1'b1, 5, 1, 0, 8'hC3};

        reset = 1'b1;
        tick  = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset data",        32'(data),        32'h0);
        check("reset valid",       32'(valid),       32'h0);
        check("reset frame_error", 32'(frame_error), 32'h0);
        check("reset busy",        32'(busy),        32'h0);

        idle_line(20, 1'b1);

        for (int v = 0; v < 4; v++) begin
            idle_line(30, 1'b1);
            clear_obs();
            run_frame(vecs[v].word, vecs[v].stop_bit, vecs[v].tail, vecs[v].div, 60, -1);
            check($sformatf("%s valid pulses", vecs[v].name), 32'(n_valid), 32'(vecs[v].exp_valid));
            check($sformatf("%s ferr pulses", vecs[v].name),  32'(n_ferr),  32'(vecs[v].exp_ferr));
            check($sformatf("%s both high", vecs[v].name),    32'(n_both),  32'h0);
            check($sformatf("%s data", vecs[v].name),         32'(data),    32'(vecs[v].exp_data));
            check($sformatf("%s busy end", vecs[v].name),     32'(busy),    32'h0);
            if (vecs[v].exp_valid != 0) begin
                check($sformatf("%s valid cycle", vecs[v].name), 32'(first_valid),
                      32'(3 + (OVS / 2 - 1 + OVS * (NB + 1)) * vecs[v].div));
            end
        end

        // Short low glitch: false start, no pulses
        idle_line(30, 1'b1);
        clear_obs();
        for (int j = 0; j < 4; j++) begin
            @(posedge clock); #1;
            observe(j);
            rx   = 1'b0;
            tick = 1'b1;
        end
        idle_line(40, 1'b1);
        check("glitch busy seen",  32'(saw_busy), 32'h1);
        check("glitch busy end",   32'(busy),     32'h0);
        check("glitch valid",      32'(n_valid),  32'h0);
        check("glitch ferr",       32'(n_ferr),   32'h0);
        check("glitch data",       32'(data),     32'hC3);

        // Back-to-back frames separated only by the stop bit
        idle_line(30, 1'b1);
        clear_obs();
        run_frame(8'h00, 1'b1, 1'b1, 1, 0, -1);
        check("b2b first valid", 32'(n_valid), 32'h1);
        check("b2b first data",  32'(data),    32'h00);
        clear_obs();
        run_frame(8'hFF, 1'b1, 1'b1, 1, 40, -1);
        check("b2b second valid", 32'(n_valid), 32'h1);
        check("b2b second ferr",  32'(n_ferr),  32'h0);
        check("b2b second data",  32'(data),    32'hFF);

        // Reset during data bit 4 of 0x5A, then a clean 0x81
        idle_line(30, 1'b1);
        clear_obs();
        run_frame(8'h5A, 1'b1, 1'b1, 1, 100, 5 * OVS + 5);
        check("abort valid", 32'(n_valid), 32'h0);
        check("abort ferr",  32'(n_ferr),  32'h0);
        check("abort data",  32'(data),    32'h0);
        check("abort busy",  32'(busy),    32'h0);
        idle_line(30, 1'b1);
        clear_obs();
        run_frame(8'h81, 1'b1, 1'b1, 1, 40, -1);
        check("post-abort valid", 32'(n_valid), 32'h1);
        check("post-abort data",  32'(data),    32'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of payload bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, tick pulses per bit period; SHALL be even and >= 4.
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  oversample enable from the baud generator, one clock wide; all bit timing advances only on cycles with tick=1.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 data  output  DATA_BITS  last correctly framed word; holds until the next good frame.
REQ-008 valid  output  1  one-clock pulse: data updated with a good frame.
REQ-009 frame_error  output  1  one-clock pulse: stop bit sampled low.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 Frame format SHALL be 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), matching the team's TX PISO output.
REQ-012 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s plus a registered copy rx_d.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: on a tick with rx_d=1 and rx_s=0 (falling edge), clear tick counter and bit counter, go to START; a line held low SHALL NOT retrigger.
REQ-015 START: count ticks; on the tick where the counter reaches OVERSAMPLE/2-1, sample rx_s: 0 -> clear counter, go to DATA; 1 -> false start, return to IDLE with no output pulse.
REQ-016 DATA: on each tick where the counter reaches OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift), clear the counter, and increment the bit counter; after the DATA_BITS-th sample, go to STOP.
REQ-017 STOP: on the tick where the counter reaches OVERSAMPLE-1, sample rx_s: 1 -> load data from the shift register and pulse valid; 0 -> pulse frame_error, leave data unchanged; in both cases go to IDLE.
REQ-018 valid and frame_error SHALL be registered, asserted in the clock cycle after the deciding tick, and never asserted together.
REQ-019 Cycles with tick=0 SHALL leave all state unchanged except the synchronizer, rx_d, and the clearing of one-clock pulses.
REQ-020 Sample timing: start mid-sample on the OVERSAMPLE/2-th tick counting the edge tick as the 1st; data bit i sampled OVERSAMPLE*(i+1) ticks later; stop bit sampled OVERSAMPLE*(DATA_BITS+1) ticks later.
REQ-021 Tick counter width SHALL be clog2(OVERSAMPLE); bit counter width SHALL be clog2(DATA_BITS+1); no wrap outside the rules above.
REQ-022 After frame_error, a new frame SHALL require rx_s to return high and then fall.

Reset
REQ-023 While reset=1: state=IDLE, counters=0, shift register=0, data=0, valid=0, frame_error=0, busy=0, synchronizer flops and rx_d=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_error pulse; after release, reception resumes only on a fresh falling edge.

Structure
REQ-025 Shared package uart_pkg SHALL hold the rx state enum and the default DATA_BITS and OVERSAMPLE constants, shared with TX.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module, bit_synchronizer (reset value parameterized, here 1).
REQ-027 The FSM, counters, and shift register SHALL reside in uart_rx; the target size is 120-400 RTL lines.

Verification (DATA_BITS=8, OVERSAMPLE=16, tick=1 every cycle unless stated)
REQ-028 Send 0xA5 with a good stop bit -> data=0xA5, one valid pulse, frame_error never high, busy low after the frame.
REQ-029 Send 0x3C with the stop bit driven 0 -> one frame_error pulse, no valid, data keeps its prior value; the line held low produces no further pulses until it goes high and falls again.
REQ-030 Drive a 4-tick low glitch on the idle line -> false start, busy drops, no valid or frame_error pulse.
REQ-031 Send 0x00 then 0xFF back-to-back, with one idle stop bit between -> two valid pulses with data 0x00 then 0xFF.
REQ-032 Assert reset for 2 cycles during bit 4 of 0x5A, then send 0x81 -> no pulse for the aborted frame; data=0x81 with one valid pulse.
REQ-033 Pulse tick once every 5 clocks and send 0xC3 -> data=0xC3, valid asserted exactly 1 clock after the stop-sampling tick, and valid lasts 1 clock.
